// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus command encoding, tag owner
// type and default tag width.
package mem_arbiter_pkg;

   localparam int unsigned TAG_W = 4;

   localparam logic [1:0] BUS_NONE  = 2'h0;
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;

   typedef enum logic {
      OWN_D = 1'b0,
      OWN_I = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Records which cache owns each outstanding memory load tag, counts valid entries and
// flags protocol errors (returns of unknown tags, allocations over live tags).
module mem_tag_owner_table
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TAG_W = mem_arbiter_pkg::TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   // allocate port
   input  logic             alloc_en,
   input  logic [TAG_W-1:0] alloc_tag,
   input  owner_e           alloc_owner,
   // clear port
   input  logic             clr_en,
   input  logic [TAG_W-1:0] clr_tag,
   // lookup port
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   output owner_e           lookup_owner,
   output logic [TAG_W-1:0] outstanding,
   output logic             tag_error
);

   localparam int unsigned Entries = 1 << TAG_W;

   logic [Entries-1:0] valid_q, valid_d;
   logic [Entries-1:0] owner_q, owner_d;
   logic [TAG_W-1:0]   outstanding_q, outstanding_d;
   logic               tag_error_q, tag_error_d;
   logic               clr_same, alloc_new, alloc_overwrite, lookup_miss;

   assign lookup_hit   = (lookup_tag != '0) && valid_q[lookup_tag];
   assign lookup_owner = owner_e'(owner_q[lookup_tag]);
   assign outstanding  = outstanding_q;
   assign tag_error    = tag_error_q;

   // A live entry being retired this very cycle may be reallocated without error.
   assign clr_same        = clr_en && (clr_tag == alloc_tag);
   assign alloc_new       = alloc_en && (!valid_q[alloc_tag] || clr_same);
   assign alloc_overwrite = alloc_en && valid_q[alloc_tag] && !clr_same;
   assign lookup_miss     = (lookup_tag != '0) && !valid_q[lookup_tag];

   always_comb begin
      valid_d       = valid_q;
      owner_d       = owner_q;
      outstanding_d = outstanding_q;
      tag_error_d   = tag_error_q | lookup_miss | alloc_overwrite;
      if (clr_en) begin
         valid_d[clr_tag] = 1'b0;
      end
      if (alloc_en) begin
         valid_d[alloc_tag] = 1'b1;
         owner_d[alloc_tag] = alloc_owner;
      end
      unique case ({alloc_new, clr_en})
         2'b10:   outstanding_d = outstanding_q + TAG_W'(1);
         2'b01:   outstanding_d = outstanding_q - TAG_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q       <= '0;
         owner_q       <= '0;
         outstanding_q <= '0;
         tag_error_q   <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         owner_q       <= owner_d;
         outstanding_q <= outstanding_d;
         tag_error_q   <= tag_error_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory bus between dcache and icache (dcache priority with
// icache starvation relief) and steers accept/return tags back to their owner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TAG_W        = mem_arbiter_pkg::TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       proc2Dmem_command,
   input  logic [63:0]      proc2Dmem_addr,
   input  logic [63:0]      proc2Dmem_data,
   input  logic [1:0]       proc2Imem_command,
   input  logic [63:0]      proc2Imem_addr,
   input  logic [TAG_W-1:0] mem2proc_response,
   input  logic [63:0]      mem2proc_data,
   input  logic [TAG_W-1:0] mem2proc_tag,
   input  logic             halt_req,
   output logic [1:0]       proc2mem_command,
   output logic [63:0]      proc2mem_addr,
   output logic [63:0]      proc2mem_data,
   output logic [TAG_W-1:0] Dmem2proc_response,
   output logic [TAG_W-1:0] Imem2proc_response,
   output logic [TAG_W-1:0] Dmem2proc_tag,
   output logic [TAG_W-1:0] Imem2proc_tag,
   output logic [63:0]      Dmem2proc_data,
   output logic [63:0]      Imem2proc_data,
   output logic [TAG_W-1:0] outstanding,
   output logic             halt_done,
   output logic             tag_error
);

   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

   logic             d_req, i_req, grant_d, grant_i;
   logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
   logic             halt_seen_q, halt_seen_d;
   logic             alloc_en;
   owner_e           alloc_owner;
   logic             lookup_hit;
   owner_e           lookup_owner;
   logic [TAG_W-1:0] tbl_outstanding;
   logic             tbl_error;

   assign d_req   = (proc2Dmem_command != BUS_NONE);
   assign i_req   = (proc2Imem_command != BUS_NONE);
   assign grant_i = i_req && (!d_req || (starve_cnt_q == StarveMax));
   assign grant_d = d_req && !grant_i;

   assign alloc_en    = reset && (mem2proc_response != '0) &&
                        ((grant_d && (proc2Dmem_command == BUS_LOAD)) ||
                         (grant_i && (proc2Imem_command == BUS_LOAD)));
   assign alloc_owner = grant_i ? OWN_I : OWN_D;

   mem_tag_owner_table #(
      .TAG_W(TAG_W)
   ) u_owner_table (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (alloc_en),
      .alloc_tag   (mem2proc_response),
      .alloc_owner (alloc_owner),
      .clr_en      (lookup_hit),
      .clr_tag     (mem2proc_tag),
      .lookup_tag  (mem2proc_tag),
      .lookup_hit  (lookup_hit),
      .lookup_owner(lookup_owner),
      .outstanding (tbl_outstanding),
      .tag_error   (tbl_error)
   );

   // Rejected icache grants hold the count so a retry keeps its forced priority.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      halt_seen_d  = halt_seen_q | halt_req;
      if (!i_req) begin
         starve_cnt_d = '0;
      end else if (grant_i) begin
         if (mem2proc_response != '0) begin
            starve_cnt_d = '0;
         end
      end else if (starve_cnt_q != StarveMax) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= '0;
         halt_seen_q  <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         halt_seen_q  <= halt_seen_d;
      end
   end

   // Every output is held at zero while reset is asserted.
   always_comb begin
      proc2mem_command   = BUS_NONE;
      proc2mem_addr      = '0;
      proc2mem_data      = '0;
      Dmem2proc_response = '0;
      Imem2proc_response = '0;
      Dmem2proc_tag      = '0;
      Imem2proc_tag      = '0;
      Dmem2proc_data     = '0;
      Imem2proc_data     = '0;
      outstanding        = '0;
      halt_done          = 1'b0;
      tag_error          = 1'b0;
      if (reset) begin
         if (grant_d) begin
            proc2mem_command   = proc2Dmem_command;
            proc2mem_addr      = proc2Dmem_addr;
            proc2mem_data      = proc2Dmem_data;
            Dmem2proc_response = mem2proc_response;
         end else if (grant_i) begin
            proc2mem_command   = proc2Imem_command;
            proc2mem_addr      = proc2Imem_addr;
            Imem2proc_response = mem2proc_response;
         end
         if (lookup_hit) begin
            if (lookup_owner == OWN_D) begin
               Dmem2proc_tag = mem2proc_tag;
            end else begin
               Imem2proc_tag = mem2proc_tag;
            end
         end
         Dmem2proc_data = mem2proc_data;
         Imem2proc_data = mem2proc_data;
         outstanding    = tbl_outstanding;
         tag_error      = tbl_error;
         halt_done      = halt_seen_q && (tbl_outstanding == '0) && !d_req && !i_req;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a map-based reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned STARVE = 4;
   localparam int unsigned TW     = 4;
   localparam logic [63:0] D_ADDR = 64'h0000_0000_0000_1000;
   localparam logic [63:0] I_ADDR = 64'h0000_0000_0000_2000;
   localparam logic [63:0] D_DATA = 64'hD0D0_D0D0_1234_5678;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    proc2Dmem_command, proc2Imem_command, proc2mem_command;
   logic [63:0]   proc2Dmem_addr, proc2Dmem_data, proc2Imem_addr, mem2proc_data;
   logic [63:0]   proc2mem_addr, proc2mem_data, Dmem2proc_data, Imem2proc_data;
   logic [TW-1:0] mem2proc_response, mem2proc_tag;
   logic [TW-1:0] Dmem2proc_response, Imem2proc_response, Dmem2proc_tag, Imem2proc_tag;
   logic [TW-1:0] outstanding;
   logic          halt_req, halt_done, tag_error;

   mem_arbiter #(
      .STARVE_LIMIT(STARVE),
      .TAG_W       (TW)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .proc2Dmem_command (proc2Dmem_command),
      .proc2Dmem_addr    (proc2Dmem_addr),
      .proc2Dmem_data    (proc2Dmem_data),
      .proc2Imem_command (proc2Imem_command),
      .proc2Imem_addr    (proc2Imem_addr),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag),
      .halt_req          (halt_req),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .Dmem2proc_response(Dmem2proc_response),
      .Imem2proc_response(Imem2proc_response),
      .Dmem2proc_tag     (Dmem2proc_tag),
      .Imem2proc_tag     (Imem2proc_tag),
      .Dmem2proc_data    (Dmem2proc_data),
      .Imem2proc_data    (Imem2proc_data),
      .outstanding       (outstanding),
      .halt_done         (halt_done),
      .tag_error         (tag_error)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: live tags in an associative map, plain integer counters.
   owner_e m_own[int];
   int     m_starve;
   bit     m_err;
   bit     m_halt;

   typedef struct {
      logic [1:0]    dcmd;
      logic [1:0]    icmd;
      logic [TW-1:0] resp;
      logic [TW-1:0] rtag;
      int            grant;  // 0 none, 1 dcache, 2 icache
      logic [TW-1:0] dresp;
      logic [TW-1:0] iresp;
      logic [TW-1:0] dtag;
      logic [TW-1:0] itag;
      logic [TW-1:0] outst;
      logic          err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int model_grant();
      bit dr, ir;
      dr = (proc2Dmem_command != BUS_NONE);
      ir = (proc2Imem_command != BUS_NONE);
      if (ir && (!dr || m_starve >= int'(STARVE))) return 2;
      if (dr) return 1;
      return 0;
   endfunction

   task automatic check_model();
      int            g, n;
      logic [1:0]    ecmd;
      logic [63:0]   eaddr, edata;
      logic [TW-1:0] edr, eir, edt, eit;
      logic          ehd;
      g = model_grant();
      ecmd = BUS_NONE; eaddr = '0; edata = '0; edr = '0; eir = '0; edt = '0; eit = '0;
      if (g == 1) begin
         ecmd = proc2Dmem_command; eaddr = proc2Dmem_addr; edata = proc2Dmem_data;
         edr = mem2proc_response;
      end else if (g == 2) begin
         ecmd = proc2Imem_command; eaddr = proc2Imem_addr; eir = mem2proc_response;
      end
      if (mem2proc_tag != '0 && m_own.exists(int'(mem2proc_tag))) begin
         if (m_own[int'(mem2proc_tag)] == OWN_D) edt = mem2proc_tag;
         else eit = mem2proc_tag;
      end
      n   = m_own.num();
      ehd = m_halt && (n == 0) && (proc2Dmem_command == BUS_NONE) &&
            (proc2Imem_command == BUS_NONE);
      check("m_cmd",   64'(proc2mem_command), 64'(ecmd));
      check("m_addr",  proc2mem_addr, eaddr);
      check("m_data",  proc2mem_data, edata);
      check("m_dresp", 64'(Dmem2proc_response), 64'(edr));
      check("m_iresp", 64'(Imem2proc_response), 64'(eir));
      check("m_dtag",  64'(Dmem2proc_tag), 64'(edt));
      check("m_itag",  64'(Imem2proc_tag), 64'(eit));
      check("m_ddata", Dmem2proc_data, mem2proc_data);
      check("m_idata", Imem2proc_data, mem2proc_data);
      check("m_outstanding", 64'(outstanding), 64'(n));
      check("m_tag_error", 64'(tag_error), 64'(m_err));
      check("m_halt_done", 64'(halt_done), 64'(ehd));
   endtask

   task automatic model_update();
      int  g, rt, rs;
      bit  routed, alloc;
      g      = model_grant();
      rt     = int'(mem2proc_tag);
      rs     = int'(mem2proc_response);
      routed = (rt != 0) && m_own.exists(rt);
      alloc  = (rs != 0) && ((g == 1 && proc2Dmem_command == BUS_LOAD) ||
                             (g == 2 && proc2Imem_command == BUS_LOAD));
      if (rt != 0 && !routed) m_err = 1'b1;
      if (alloc && m_own.exists(rs) && !(routed && rt == rs)) m_err = 1'b1;
      if (routed) m_own.delete(rt);
      if (alloc) begin
         if (g == 1) m_own[rs] = OWN_D;
         else m_own[rs] = OWN_I;
      end
      if (proc2Imem_command == BUS_NONE) m_starve = 0;
      else if (g == 2) begin
         if (rs != 0) m_starve = 0;
      end else if (m_starve < int'(STARVE)) m_starve++;
      if (halt_req) m_halt = 1'b1;
   endtask

   task automatic advance();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic set_in(input logic [1:0] d, input logic [1:0] i, input logic [TW-1:0] rsp,
                         input logic [TW-1:0] rt);
      proc2Dmem_command = d;
      proc2Imem_command = i;
      mem2proc_response = rsp;
      mem2proc_tag      = rt;
   endtask

   task automatic model_clear();
      m_own.delete();
      m_starve = 0;
      m_err    = 1'b0;
      m_halt   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cmd"},   64'(proc2mem_command), 64'd0);
      check({tag, "_addr"},  proc2mem_addr, 64'd0);
      check({tag, "_data"},  proc2mem_data, 64'd0);
      check({tag, "_dresp"}, 64'(Dmem2proc_response), 64'd0);
      check({tag, "_iresp"}, 64'(Imem2proc_response), 64'd0);
      check({tag, "_dtag"},  64'(Dmem2proc_tag), 64'd0);
      check({tag, "_itag"},  64'(Imem2proc_tag), 64'd0);
      check({tag, "_ddata"}, Dmem2proc_data, 64'd0);
      check({tag, "_idata"}, Imem2proc_data, 64'd0);
      check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
      check({tag, "_halt_done"}, 64'(halt_done), 64'd0);
      check({tag, "_tag_error"}, 64'(tag_error), 64'd0);
   endtask

   initial begin
      int keys[$];
      int free[$];
      logic [1:0]  ecmd;
      logic [63:0] eaddr, edata;

      // Vectors run back to back from a fresh reset; expectations are hand-derived.
      vecs.push_back('{BUS_LOAD,  BUS_LOAD, 4'd3, 4'd0, 1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd3, 0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd1, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_LOAD, 4'd0, 4'd0, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_LOAD, 4'd0, 4'd0, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_LOAD, 4'd0, 4'd0, 2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_LOAD, 4'd5, 4'd0, 2, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd5, 0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd1, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_LOAD, 4'd2, 4'd0, 2, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_LOAD,  BUS_NONE, 4'd2, 4'd2, 1, 4'd2, 4'd0, 4'd0, 4'd2, 4'd1, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd2, 0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd1, 1'b0});
      vecs.push_back('{BUS_STORE, BUS_NONE, 4'd7, 4'd0, 1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd7, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
      vecs.push_back('{BUS_NONE,  BUS_NONE, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1});

      proc2Dmem_addr = D_ADDR;
      proc2Dmem_data = D_DATA;
      proc2Imem_addr = I_ADDR;
      mem2proc_data  = 64'hCAFE_F00D_0BAD_BEEF;
      halt_req       = 1'b0;
      model_clear();

      // Outputs stay zero under reset even with live inputs.
      reset = 1'b0;
      set_in(BUS_LOAD, BUS_LOAD, 4'd3, 4'd3);
      #3 check_zero("rst");
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd0);
      do_reset();

      foreach (vecs[k]) begin
         set_in(vecs[k].dcmd, vecs[k].icmd, vecs[k].resp, vecs[k].rtag);
         @(negedge clock);
         ecmd  = (vecs[k].grant == 1) ? vecs[k].dcmd : (vecs[k].grant == 2) ? vecs[k].icmd : BUS_NONE;
         eaddr = (vecs[k].grant == 1) ? D_ADDR : (vecs[k].grant == 2) ? I_ADDR : 64'd0;
         edata = (vecs[k].grant == 1) ? D_DATA : 64'd0;
         check($sformatf("v%0d_cmd", k), 64'(proc2mem_command), 64'(ecmd));
         check($sformatf("v%0d_addr", k), proc2mem_addr, eaddr);
         check($sformatf("v%0d_data", k), proc2mem_data, edata);
         check($sformatf("v%0d_dresp", k), 64'(Dmem2proc_response), 64'(vecs[k].dresp));
         check($sformatf("v%0d_iresp", k), 64'(Imem2proc_response), 64'(vecs[k].iresp));
         check($sformatf("v%0d_dtag", k), 64'(Dmem2proc_tag), 64'(vecs[k].dtag));
         check($sformatf("v%0d_itag", k), 64'(Imem2proc_tag), 64'(vecs[k].itag));
         check($sformatf("v%0d_outstanding", k), 64'(outstanding), 64'(vecs[k].outst));
         check($sformatf("v%0d_tag_error", k), 64'(tag_error), 64'(vecs[k].err));
         check_model();
         advance();
      end

      // Both caches request every cycle and memory accepts each: icache wins every 5th.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         set_in(BUS_LOAD, BUS_LOAD, TW'(c + 1), 4'd0);
         @(negedge clock);
         check($sformatf("starve%0d_addr", c), proc2mem_addr,
               (c == 4 || c == 9) ? I_ADDR : D_ADDR);
         check($sformatf("starve%0d_iresp", c), 64'(Imem2proc_response),
               (c == 4 || c == 9) ? 64'(c + 1) : 64'd0);
         check($sformatf("starve%0d_dresp", c), 64'(Dmem2proc_response),
               (c == 4 || c == 9) ? 64'd0 : 64'(c + 1));
         check_model();
         advance();
      end

      // Asynchronous reset in the middle of traffic drops everything at once.
      set_in(BUS_LOAD, BUS_LOAD, 4'd11, 4'd1);
      #2 reset = 1'b0;
      #1 check_zero("midrst");
      model_clear();
      @(posedge clock);
      #1 reset = 1'b1;
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd1);
      @(negedge clock);
      check_model();
      advance();
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd0);
      @(negedge clock);
      check("postrst_tag_error", 64'(tag_error), 64'd1);
      check_model();
      advance();

      // Halt with two loads outstanding: done only once both have returned.
      do_reset();
      set_in(BUS_LOAD, BUS_NONE, 4'd1, 4'd0);
      advance();
      set_in(BUS_LOAD, BUS_NONE, 4'd2, 4'd0);
      halt_req = 1'b1;
      advance();
      halt_req = 1'b0;
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd0);
      @(negedge clock);
      check("halt_wait0", 64'(halt_done), 64'd0);
      check("halt_outst2", 64'(outstanding), 64'd2);
      advance();
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd1);
      @(negedge clock);
      check("halt_wait1", 64'(halt_done), 64'd0);
      check("halt_dtag1", 64'(Dmem2proc_tag), 64'd1);
      advance();
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd2);
      @(negedge clock);
      check("halt_wait2", 64'(halt_done), 64'd0);
      advance();
      set_in(BUS_NONE, BUS_NONE, 4'd0, 4'd0);
      @(negedge clock);
      check("halt_done", 64'(halt_done), 64'd1);
      check_model();
      advance();

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         keys.delete();
         free.delete();
         foreach (m_own[t]) keys.push_back(t);
         for (int t = 1; t < (1 << TW); t++) if (!m_own.exists(t)) free.push_back(t);
         proc2Dmem_command = 2'($urandom_range(0, 2));
         proc2Imem_command = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
         proc2Dmem_addr    = {$urandom, $urandom};
         proc2Dmem_data    = {$urandom, $urandom};
         proc2Imem_addr    = {$urandom, $urandom};
         mem2proc_data     = {$urandom, $urandom};
         halt_req          = ($urandom_range(0, 99) == 0);
         if (free.size() > 0 && $urandom_range(0, 4) != 0)
            mem2proc_response = TW'(free[$urandom_range(0, free.size() - 1)]);
         else
            mem2proc_response = '0;
         if ($urandom_range(0, 79) == 0)
            mem2proc_tag = TW'($urandom_range(1, (1 << TW) - 1));
         else if (keys.size() > 0 && $urandom_range(0, 1) == 1)
            mem2proc_tag = TW'(keys[$urandom_range(0, keys.size() - 1)]);
         else
            mem2proc_tag = '0;
         @(negedge clock);
         check_model();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
